motor_drive_controller: RTL and testbench



---
 rtl/motor_drive_controller.sv | 209 ++++++++++++++++++++
 tb/tb_motor_drive_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_drive_controller.sv
// motor_drive_controller
// Turns the navigation state code into two PWM-driven H-bridge channels.
// Duty ramps one count per ramp tick. Any reversal first brakes to zero
// duty and then waits a dead time, so the wheels never reverse instantly.
//
// State encoding on dbg_state_o: 0 STOPPED, 1 DRIVING, 2 BRAKING, 3 DEAD.
// The direction input has no handshake. It is a level that is registered
// on every clock, and the registered code is decoded in the next cycle.
module motor_drive_controller #(
    parameter int PWM_PERIOD = 1000,   // <= 1023
    parameter int DUTY_DRIVE = 700,    // <= PWM_PERIOD
    parameter int DUTY_TURN  = 500,    // <= PWM_PERIOD
    parameter int RAMP_DIV   = 5000,   // clk cycles per duty step
    parameter int DEAD_TIME  = 500000  // clk cycles idle after braking
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] direction,
    output logic       left_pwm,
    output logic       left_dir,
    output logic       right_pwm,
    output logic       right_dir,
    output logic [9:0] duty_level,
    output logic       moving,
    output logic [1:0] dbg_state_o
);

    localparam int RAMP_W = $clog2(RAMP_DIV + 1);
    localparam int DEAD_W = $clog2(DEAD_TIME + 1);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_DRIVING = 2'd1,
        ST_BRAKING = 2'd2,
        ST_DEAD    = 2'd3
    } state_t;

    logic [3:0]        code_q;
    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic              tick;
    state_t            state_q, state_d;
    logic [9:0]        duty_q, duty_d;
    logic              ldir_q, ldir_d;
    logic              rdir_q, rdir_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [9:0]        pwm_cnt_q, pwm_cnt_d;
    logic [9:0]        applied_q, applied_d;
    logic              pwm_q, pwm_d;

    logic              tgt_ldir;
    logic              tgt_rdir;
    logic [9:0]        tgt_duty;
    logic              dir_mismatch;

    // Register the incoming code once. Every decision below uses this copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) code_q <= 4'd0;
        else       code_q <= direction;
    end

    // Decode the registered code into the target wheel directions and duty.
    // Idle, stop and invalid codes all request zero duty.
    always_comb begin
        tgt_ldir = 1'b1;
        tgt_rdir = 1'b1;
        tgt_duty = 10'd0;
        case (code_q)
            4'd1, 4'd3, 4'd7: begin
                tgt_ldir = 1'b1;
                tgt_rdir = 1'b1;
                tgt_duty = 10'(DUTY_DRIVE);
            end
            4'd5: begin
                tgt_ldir = 1'b0;
                tgt_rdir = 1'b0;
                tgt_duty = 10'(DUTY_DRIVE);
            end
            4'd2: begin
                tgt_ldir = 1'b0;
                tgt_rdir = 1'b1;
                tgt_duty = 10'(DUTY_TURN);
            end
            4'd6: begin
                tgt_ldir = 1'b1;
                tgt_rdir = 1'b0;
                tgt_duty = 10'(DUTY_TURN);
            end
            default: begin
                tgt_ldir = 1'b1;
                tgt_rdir = 1'b1;
                tgt_duty = 10'd0;
            end
        endcase
    end

    assign dir_mismatch = (tgt_ldir != ldir_q) || (tgt_rdir != rdir_q);

    // The ramp prescaler wraps at RAMP_DIV-1 and emits one tick per wrap.
    // Only reset clears it, so tick phase is independent of the FSM.
    assign tick       = (ramp_cnt_q == RAMP_W'(RAMP_DIV - 1));
    assign ramp_cnt_d = tick ? '0 : ramp_cnt_q + 1'b1;

    // Ramp prescaler register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ramp_cnt_q <= '0;
        else       ramp_cnt_q <= ramp_cnt_d;
    end

    // Next-state logic: ramping, braking, dead time and direction latching.
    // Directions load only in STOPPED, where duty is always zero.
    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        ldir_d     = ldir_q;
        rdir_d     = rdir_q;
        dead_cnt_d = dead_cnt_q;
        case (state_q)
            ST_STOPPED: begin
                duty_d = 10'd0;
                if (tgt_duty != 10'd0) begin
                    ldir_d  = tgt_ldir;
                    rdir_d  = tgt_rdir;
                    state_d = ST_DRIVING;
                end
            end
            ST_DRIVING: begin
                if ((tgt_duty == 10'd0) || dir_mismatch) begin
                    state_d = ST_BRAKING;
                end else if (tick) begin
                    if (duty_q < tgt_duty)      duty_d = duty_q + 10'd1;
                    else if (duty_q > tgt_duty) duty_d = duty_q - 10'd1;
                end
            end
            ST_BRAKING: begin
                // Target changes are ignored until the dead time has passed.
                if (duty_q == 10'd0) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = '0;
                end else if (tick) begin
                    duty_d = duty_q - 10'd1;
                end
            end
            ST_DEAD: begin
                duty_d = 10'd0;
                if (dead_cnt_q == DEAD_W'(DEAD_TIME - 1)) begin
                    state_d    = ST_STOPPED;
                    dead_cnt_d = '0;
                end else begin
                    dead_cnt_d = dead_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STOPPED;
                duty_d  = 10'd0;
            end
        endcase
    end

    // FSM, duty and direction registers. Directions reset to forward.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_STOPPED;
            duty_q     <= 10'd0;
            ldir_q     <= 1'b1;
            rdir_q     <= 1'b1;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            ldir_q     <= ldir_d;
            rdir_q     <= rdir_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    // PWM counter next value. The applied duty changes only at the period
    // boundary, so a period never contains two different duty values.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 10'd1;
        applied_d = applied_q;
        if (pwm_cnt_q == 10'(PWM_PERIOD - 1)) begin
            pwm_cnt_d = 10'd0;
            applied_d = duty_q;
        end
        pwm_d = (pwm_cnt_q < applied_q);
    end

    // PWM registers. The output is registered so the pins never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= 10'd0;
            applied_q <= 10'd0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            applied_q <= applied_d;
            pwm_q     <= pwm_d;
        end
    end

    assign left_pwm    = pwm_q;
    assign right_pwm   = pwm_q;
    assign left_dir    = ldir_q;
    assign right_dir   = rdir_q;
    assign duty_level  = duty_q;
    assign moving      = (duty_q != 10'd0);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_motor_drive_controller.sv
// Testbench for motor_drive_controller, using small parameters so that
// ramps and dead time stay short. A behavioural model tracks the expected
// outputs on every cycle. A vector table checks the steady-state result of
// each held code, and hand-written sequences cover the reversal, reset and
// glitch-free corner cases.
module tb_motor_drive_controller;

    localparam int PWM_PERIOD = 10;
    localparam int DUTY_DRIVE = 8;
    localparam int DUTY_TURN  = 5;
    localparam int RAMP_DIV   = 2;
    localparam int DEAD_TIME  = 8;

    // Clock and reset
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] direction;
    logic       left_pwm, left_dir, right_pwm, right_dir, moving;
    logic [9:0] duty_level;
    logic [1:0] dbg_state_o;

    always #5 clk = ~clk;

    motor_drive_controller #(
        .PWM_PERIOD(PWM_PERIOD), .DUTY_DRIVE(DUTY_DRIVE), .DUTY_TURN(DUTY_TURN),
        .RAMP_DIV(RAMP_DIV), .DEAD_TIME(DEAD_TIME)
    ) dut (
        .clk(clk), .reset(reset), .direction(direction),
        .left_pwm(left_pwm), .left_dir(left_dir),
        .right_pwm(right_pwm), .right_dir(right_dir),
        .duty_level(duty_level), .moving(moving), .dbg_state_o(dbg_state_o)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model. It counts elapsed clock edges and derives tick and
    // PWM phase from them arithmetically. The motion phase is a small
    // "what the wheels are doing" label.
    localparam int PH_REST  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_BRAKE = 2;
    localparam int PH_WAIT  = 3;

    int m_k, m_code, m_phase, m_duty, m_wait, m_applied;
    bit m_ldir, m_rdir, m_pwm;
    int prev_duty;
    bit prev_ldir, prev_rdir;

    task automatic target_of(input int code, output bit tl, output bit tr, output int td);
        tl = 1'b1; tr = 1'b1; td = 0;
        if (code == 1 || code == 3 || code == 7) td = DUTY_DRIVE;
        else if (code == 5) begin tl = 1'b0; tr = 1'b0; td = DUTY_DRIVE; end
        else if (code == 2) begin tl = 1'b0; td = DUTY_TURN; end
        else if (code == 6) begin tr = 1'b0; td = DUTY_TURN; end
    endtask

    task automatic model_reset();
        m_k = 0; m_code = 0; m_phase = PH_REST; m_duty = 0; m_wait = 0;
        m_applied = 0; m_ldir = 1'b1; m_rdir = 1'b1; m_pwm = 1'b0;
        prev_duty = 0; prev_ldir = 1'b1; prev_rdir = 1'b1;
    endtask

    task automatic model_step(input int code_in);
        bit tick, tl, tr;
        int td, ph;
        tick = (m_k % RAMP_DIV) == RAMP_DIV - 1;
        target_of(m_code, tl, tr, td);
        ph = m_k % PWM_PERIOD;
        m_pwm = (ph < m_applied);
        if (ph == PWM_PERIOD - 1) m_applied = m_duty;
        if (m_phase == PH_REST) begin
            if (td > 0) begin m_ldir = tl; m_rdir = tr; m_phase = PH_RUN; end
        end else if (m_phase == PH_RUN) begin
            if (td == 0 || tl != m_ldir || tr != m_rdir) m_phase = PH_BRAKE;
            else if (tick && m_duty < td) m_duty++;
            else if (tick && m_duty > td) m_duty--;
        end else if (m_phase == PH_BRAKE) begin
            if (m_duty == 0) begin m_phase = PH_WAIT; m_wait = DEAD_TIME; end
            else if (tick) m_duty--;
        end else begin
            m_wait--;
            if (m_wait == 0) m_phase = PH_REST;
        end
        m_code = code_in;
        m_k++;
    endtask

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step(int'(direction));
        @(negedge clk);
        check("duty_level", duty_level, m_duty);
        check("moving", moving, (m_duty != 0));
        check("dirs", {left_dir, right_dir}, {m_ldir, m_rdir});
        check("pwm", {left_pwm, right_pwm}, {m_pwm, m_pwm});
        if (left_dir != prev_ldir || right_dir != prev_rdir)
            check("dir_change_at_zero_duty", prev_duty, 0);
        prev_duty = int'(duty_level);
        prev_ldir = left_dir;
        prev_rdir = right_dir;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    typedef struct {
        logic [3:0] code;
        int         hold;
        int         exp_duty;
        bit         exp_ldir;
        bit         exp_rdir;
        bit         exp_moving;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int dead_n, min_duty, hi_l, hi_r, waited;
        bit found;

        vecs[0]  = '{4'd0,  10, 0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{4'd1,  40, 8, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{4'd3,  10, 8, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{4'd2,  60, 5, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{4'd6,  60, 5, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{4'd5,  60, 8, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{4'd12, 60, 0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'd7,  40, 8, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{4'd8,  40, 0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{4'd2,  40, 5, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{4'd15, 40, 0, 1'b0, 1'b1, 1'b0};

        // Reset state
        reset = 1'b1;
        direction = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_duty", duty_level, 0);
        check("reset_pwm", {left_pwm, right_pwm}, 2'b00);
        check("reset_dirs", {left_dir, right_dir}, 2'b11);
        check("reset_moving", moving, 0);
        check("reset_state", dbg_state_o, 0);
        reset = 1'b0;
        model_reset();

        // Table-driven steady-state vectors
        for (int v = 0; v < 11; v++) begin
            direction = vecs[v].code;
            run(vecs[v].hold);
            check($sformatf("vec%0d_duty", v), duty_level, vecs[v].exp_duty);
            check($sformatf("vec%0d_dirs", v), {left_dir, right_dir},
                  {vecs[v].exp_ldir, vecs[v].exp_rdir});
            check($sformatf("vec%0d_moving", v), moving, vecs[v].exp_moving);
            check($sformatf("vec%0d_pwm_low_when_idle", v),
                  (vecs[v].exp_duty == 0) ? {left_pwm, right_pwm} : 2'b00, 2'b00);
        end

        // A reversal requested briefly is braked through the full dead time
        direction = 4'd1;
        run(40);
        direction = 4'd5;
        run(2);
        direction = 4'd1;
        dead_n = 0;
        min_duty = 1023;
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (dbg_state_o == 2'd3) dead_n++;
            if (int'(duty_level) < min_duty) min_duty = int'(duty_level);
        end
        check("blip_dead_cycles", dead_n, DEAD_TIME);
        check("blip_min_duty", min_duty, 0);
        check("blip_final_duty", duty_level, DUTY_DRIVE);
        check("blip_final_dirs", {left_dir, right_dir}, 2'b11);

        // Steady PWM has 8 high cycles in every 10. Switching code 1 to 3
        // keeps the waveform intact.
        for (int w = 0; w < 4; w++) begin
            if (w == 1) direction = 4'd3;
            hi_l = 0;
            hi_r = 0;
            for (int i = 0; i < PWM_PERIOD; i++) begin
                cycle();
                hi_l += int'(left_pwm);
                hi_r += int'(right_pwm);
            end
            check($sformatf("pwm_window%0d_left", w), hi_l, DUTY_DRIVE);
            check($sformatf("pwm_window%0d_right", w), hi_r, DUTY_DRIVE);
        end

        // Asynchronous reset in the middle of a ramp
        direction = 4'd8;
        run(40);
        direction = 4'd1;
        found = 1'b0;
        waited = 0;
        while (!found && waited < 40) begin
            cycle();
            waited++;
            if (duty_level == 10'd4) found = 1'b1;
        end
        check("reach_duty4", found, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_duty", duty_level, 0);
        check("async_rst_moving", moving, 0);
        check("async_rst_pwm", {left_pwm, right_pwm}, 2'b00);
        check("async_rst_dirs", {left_dir, right_dir}, 2'b11);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle();
        check("restart_duty0", duty_level, 0);
        run(30);
        check("restart_final_duty", duty_level, DUTY_DRIVE);

        // Random codes and hold times
        for (int s = 0; s < 60; s++) begin
            direction = 4'($urandom_range(0, 15));
            run($urandom_range(1, 40));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog: stop a runaway simulation before it hangs.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
